alu_dsp_shared: RTL and testbench

- Shared behavioural DSP slice serving every ALU calculation unit that emits a 44-bit DSP command word (`dsp_ins_flat`) and consumes an 84-bit result word (`dsp_outs_flat`).
- Arbitrates up to NCLIENTS requesters, registers the granted client's command, and runs a 3-stage multiply/accumulate pipeline.
- Broadcasts `{m, p}` to all clients.
- Sits in the ALU top between the calculation units (Taylor calc and siblings) and the single physical multiplier.

---
 rtl/alu_dsp_shared_pkg.sv | 49 ++++
 rtl/dsp_rr_arbiter.sv | 83 ++++++++
 rtl/alu_dsp_shared.sv | 91 +++++++++
 tb/tb_alu_dsp_shared.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_dsp_shared_pkg.sv
// Shared types and constants for the ALU DSP slice: command-word layout,
// X/Z operand-select codes and the arbiter state encoding.
package alu_dsp_shared_pkg;

   localparam int DSP_INS_W  = 44;
   localparam int DSP_OUTS_W = 84;
   localparam int DSP_AB_W   = 18;
   localparam int DSP_M_W    = 36;
   localparam int DSP_P_W    = 48;

   localparam logic [1:0] DSP_X_IN_ZERO = 2'd0;
   localparam logic [1:0] DSP_X_IN_MULT = 2'd1;
   localparam logic [1:0] DSP_X_IN_POUT = 2'd2;
   localparam logic [1:0] DSP_X_IN_AB   = 2'd3;

   // Z codes 1 and 3 are unused and behave like ZERO.
   localparam logic [1:0] DSP_Z_IN_ZERO = 2'd0;
   localparam logic [1:0] DSP_Z_IN_POUT = 2'd2;

   typedef struct packed {
      logic                postadd_sub;
      logic                preadd_sub;
      logic                cryin;
      logic                use_preadd;
      logic [1:0]          z_in;
      logic [1:0]          x_in;
      logic [DSP_AB_W-1:0] a;
      logic [DSP_AB_W-1:0] b;
   } dsp_cmd_t;

   // Opmode bits that travel down the pipeline alongside the data.
   typedef struct packed {
      logic       postadd_sub;
      logic       cryin;
      logic [1:0] z_in;
      logic [1:0] x_in;
   } dsp_op_t;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_OWNED = 2'd1,
      ARB_FLUSH = 2'd2
   } arb_state_t;

   function automatic logic [DSP_P_W-1:0] sext_p(input logic [DSP_M_W-1:0] v);
      return {{(DSP_P_W-DSP_M_W){v[DSP_M_W-1]}}, v};
   endfunction

endpackage

// File: rtl/dsp_rr_arbiter.sv
// Round-robin owner arbiter for the shared DSP slice. A grant is held for a
// whole calculation; releasing it costs one FLUSH cycle that clears P.
module dsp_rr_arbiter
   import alu_dsp_shared_pkg::*;
#(
   parameter int NCLIENTS = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NCLIENTS-1:0] req,
   output logic [NCLIENTS-1:0] gnt,
   output logic                flush
);

   localparam int PTR_W = (NCLIENTS > 1) ? $clog2(NCLIENTS) : 1;

   arb_state_t          state, state_nxt;
   logic [PTR_W-1:0]    rr_ptr, rr_ptr_nxt;
   logic [PTR_W-1:0]    owner, owner_nxt;
   logic [PTR_W-1:0]    pick;
   logic                found;
   logic [NCLIENTS-1:0] gnt_nxt;

   // Lowest-index requester at or after rr_ptr, wrapping around.
   always_comb begin
      int idx;
      found = 1'b0;
      pick  = '0;
      for (int k = 0; k < NCLIENTS; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NCLIENTS) idx = idx - NCLIENTS;
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = PTR_W'(idx);
         end
      end
   end

   // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_nxt  = state;
      gnt_nxt    = gnt;
      owner_nxt  = owner;
      rr_ptr_nxt = rr_ptr;
      case (state)
         ARB_IDLE: begin
            if (found) begin
               gnt_nxt       = '0;
               gnt_nxt[pick] = 1'b1;
               owner_nxt     = pick;
               state_nxt     = ARB_OWNED;
            end
         end
         ARB_OWNED: begin
            if (!req[owner]) begin
               gnt_nxt    = '0;
               rr_ptr_nxt = (int'(owner) + 1 == NCLIENTS) ? '0 : owner + 1'b1;
               state_nxt  = ARB_FLUSH;
            end
         end
         ARB_FLUSH: state_nxt = ARB_IDLE;
         default:   state_nxt = ARB_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of process order.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= ARB_IDLE;
         gnt    <= '0;
         owner  <= '0;
         rr_ptr <= '0;
      end else begin
         state  <= state_nxt;
         gnt    <= gnt_nxt;
         owner  <= owner_nxt;
         rr_ptr <= rr_ptr_nxt;
      end
   end

   assign flush = (state == ARB_FLUSH);

endmodule

// File: rtl/alu_dsp_shared.sv
// Shared DSP slice: arbitrates ALU calculation units onto one 3-stage
// pre-add / multiply / accumulate pipeline and broadcasts {M, P} to all of them.
module alu_dsp_shared
   import alu_dsp_shared_pkg::*;
#(
   parameter int NCLIENTS = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NCLIENTS-1:0]           req,
   output logic [NCLIENTS-1:0]           gnt,
   input  logic [DSP_INS_W*NCLIENTS-1:0] dsp_ins_all,
   output logic [DSP_OUTS_W-1:0]         dsp_outs_flat,
   output logic                          busy
);

   logic                flush;
   dsp_cmd_t            cmd;
   logic [DSP_AB_W-1:0] b_pre;

   logic [DSP_AB_W-1:0] a1, b1;
   logic [DSP_M_W-1:0]  ab1, ab2;
   dsp_op_t             op1, op2;
   logic [DSP_M_W-1:0]  m_reg;
   logic [DSP_P_W-1:0]  p_reg, p_nxt;
   logic [DSP_P_W-1:0]  x_val, z_val, x_sum;

   dsp_rr_arbiter #(.NCLIENTS(NCLIENTS)) u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .gnt   (gnt),
      .flush (flush)
   );

   // Without a grant the all-zero command (X=ZERO, Z=ZERO) drains the pipe.
   always_comb begin
      cmd = '0;
      for (int i = 0; i < NCLIENTS; i++) begin
         if (gnt[i]) cmd = dsp_ins_all[DSP_INS_W*i +: DSP_INS_W];
      end
   end

   always_comb begin
      b_pre = cmd.b;
      if (cmd.use_preadd) b_pre = cmd.preadd_sub ? cmd.b - cmd.a : cmd.b + cmd.a;
   end

   always_comb begin
      x_val = '0;
      case (op2.x_in)
         DSP_X_IN_ZERO: x_val = '0;
         DSP_X_IN_MULT: x_val = sext_p(m_reg);
         DSP_X_IN_POUT: x_val = p_reg;
         DSP_X_IN_AB:   x_val = sext_p(ab2);
         default:       x_val = '0;
      endcase
      z_val = (op2.z_in == DSP_Z_IN_POUT) ? p_reg : '0;
      x_sum = x_val + {{(DSP_P_W-1){1'b0}}, op2.cryin};
      p_nxt = op2.postadd_sub ? z_val - x_sum : z_val + x_sum;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         a1    <= '0;
         b1    <= '0;
         ab1   <= '0;
         op1   <= '0;
         m_reg <= '0;
         ab2   <= '0;
         op2   <= '0;
         p_reg <= '0;
      end else begin
         a1    <= cmd.a;
         b1    <= b_pre;
         ab1   <= {cmd.a, cmd.b};
         op1   <= '{postadd_sub: cmd.postadd_sub, cryin: cmd.cryin,
                    z_in: cmd.z_in, x_in: cmd.x_in};
         // Operands widened to 36 bits so the low half is the exact signed product.
         m_reg <= $signed({{DSP_AB_W{a1[DSP_AB_W-1]}}, a1})
                * $signed({{DSP_AB_W{b1[DSP_AB_W-1]}}, b1});
         ab2   <= ab1;
         op2   <= op1;
         p_reg <= flush ? '0 : p_nxt;
      end
   end

   assign dsp_outs_flat = {m_reg, p_reg};
   assign busy          = |gnt;

endmodule

// File: tb/tb_alu_dsp_shared.sv
// Bench for alu_dsp_shared: directed vector table, arbitration sequences and
// a randomized run against a cycle-level reference model.
module tb_alu_dsp_shared;

   localparam int N = 4;
   localparam int W = 44;

   logic             clk = 1'b0;
   logic             reset;
   logic [N-1:0]     req;
   logic [N-1:0]     gnt;
   logic [W*N-1:0]   dsp_ins_all;
   logic [83:0]      dsp_outs_flat;
   logic             busy;

   int n_checks = 0;
   int n_fail   = 0;

   alu_dsp_shared #(.NCLIENTS(N)) dut (
      .clk           (clk),
      .reset         (reset),
      .req           (req),
      .gnt           (gnt),
      .dsp_ins_all   (dsp_ins_all),
      .dsp_outs_flat (dsp_outs_flat),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [43:0] make_cmd(input logic post, input logic pre, input logic cin,
                                             input logic usep, input logic [1:0] z, input logic [1:0] x,
                                             input logic [17:0] a, input logic [17:0] b);
      return {post, pre, cin, usep, z, x, a, b};
   endfunction

   function automatic logic [43:0] rand_cmd();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return r[43:0];
   endfunction

   // Reference: product of a command after its optional pre-add.
   function automatic logic [35:0] ref_mul(input logic [43:0] c);
      logic signed [17:0] a, b, bp;
      longint prod;
      a = c[35:18];
      b = c[17:0];
      if (c[40]) bp = c[42] ? b - a : b + a;
      else       bp = b;
      prod = longint'(a) * longint'(bp);
      return prod[35:0];
   endfunction

   // Reference: P after applying command c to previous P.
   function automatic logic [47:0] ref_pstep(input logic [43:0] c, input logic [47:0] p);
      logic [35:0] m;
      logic [47:0] x, z;
      m = ref_mul(c);
      case (c[37:36])
         2'd1:    x = {{12{m[35]}}, m};
         2'd2:    x = p;
         2'd3:    x = {{12{c[35]}}, c[35:0]};
         default: x = '0;
      endcase
      z = (c[39:38] == 2'd2) ? p : 48'd0;
      return c[43] ? z - x - 48'(c[41]) : z + x + 48'(c[41]);
   endfunction

   // Model state: owner (-1 = no grant), flush pending, history of sampled commands.
   int          mdl_owner, mdl_ptr;
   bit          mdl_flush;
   logic [43:0] h1, h2;
   logic [35:0] mdl_m;
   logic [47:0] mdl_p;

   task automatic model_edge();
      logic [43:0] cmd_now;
      logic [47:0] p_new;
      bit          got;
      if (!reset) begin
         mdl_owner = -1; mdl_ptr = 0; mdl_flush = 0;
         h1 = '0; h2 = '0; mdl_m = '0; mdl_p = '0;
      end else begin
         cmd_now = (mdl_owner >= 0) ? dsp_ins_all[W*mdl_owner +: W] : 44'd0;
         p_new   = mdl_flush ? 48'd0 : ref_pstep(h2, mdl_p);
         mdl_m   = ref_mul(h1);
         h2      = h1;
         h1      = cmd_now;
         mdl_p   = p_new;
         if (mdl_flush) begin
            mdl_flush = 0;
         end else if (mdl_owner < 0) begin
            got = 0;
            for (int k = 0; k < N; k++) begin
               if (!got && req[(mdl_ptr + k) % N]) begin
                  got = 1;
                  mdl_owner = (mdl_ptr + k) % N;
               end
            end
         end else if (!req[mdl_owner]) begin
            mdl_ptr   = (mdl_owner + 1) % N;
            mdl_owner = -1;
            mdl_flush = 1;
         end
      end
   endtask

   task automatic wait_grant(input int budget, output logic [N-1:0] g);
      g = '0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (gnt != '0) begin
            g = gnt;
            break;
         end
      end
   endtask

   typedef struct {
      logic        rst;
      logic [3:0]  req;
      logic [43:0] c0;
      logic [43:0] c1;
      logic [3:0]  gnt;
      logic [35:0] m;
      logic [47:0] p;
   } vec_t;

   function automatic vec_t mkv(input logic rst, input logic [3:0] rq, input logic [43:0] c0,
                                input logic [43:0] c1, input logic [3:0] g,
                                input logic [35:0] m, input logic [47:0] p);
      vec_t v;
      v.rst = rst; v.req = rq; v.c0 = c0; v.c1 = c1; v.gnt = g; v.m = m; v.p = p;
      return v;
   endfunction

   vec_t        vecs[24];
   logic [43:0] c_zero, c_mul1, c_acc, c_hold, c_pre, c_post, c_garb;

   initial begin
      logic [N-1:0] g;
      logic [3:0]   gexp;

      c_zero = '0;
      c_mul1 = make_cmd(0, 0, 0, 0, 2'd0, 2'd1, 18'h10000, 18'h08000);
      c_acc  = make_cmd(0, 0, 0, 0, 2'd2, 2'd1, 18'h08000, 18'h08000);
      c_hold = make_cmd(0, 0, 0, 0, 2'd2, 2'd0, 18'h00000, 18'h00000);
      c_pre  = make_cmd(0, 1, 0, 1, 2'd0, 2'd1, 18'h04000, 18'h10000);
      c_post = make_cmd(1, 1, 0, 1, 2'd2, 2'd1, 18'h04000, 18'h10000);
      c_garb = 44'hF3C_5A5A_9E7B;

      // Outputs listed are those seen just after the row's clock edge.
      vecs[0]  = mkv(0, 4'b1111, c_garb, c_garb, 4'b0000, 36'h0,         48'h0);
      vecs[1]  = mkv(0, 4'b1111, c_garb, c_garb, 4'b0000, 36'h0,         48'h0);
      vecs[2]  = mkv(0, 4'b1111, c_garb, c_garb, 4'b0000, 36'h0,         48'h0);
      vecs[3]  = mkv(1, 4'b0001, c_zero, c_garb, 4'b0001, 36'h0,         48'h0);
      vecs[4]  = mkv(1, 4'b0001, c_mul1, c_garb, 4'b0001, 36'h0,         48'h0);
      vecs[5]  = mkv(1, 4'b0001, c_zero, c_garb, 4'b0001, 36'h0_8000_0000, 48'h0);
      vecs[6]  = mkv(1, 4'b0001, c_zero, c_garb, 4'b0001, 36'h0,         48'h0000_8000_0000);
      vecs[7]  = mkv(1, 4'b0001, c_acc,  c_garb, 4'b0001, 36'h0,         48'h0);
      vecs[8]  = mkv(1, 4'b0001, c_acc,  c_garb, 4'b0001, 36'h0_4000_0000, 48'h0);
      vecs[9]  = mkv(1, 4'b0001, c_acc,  c_garb, 4'b0001, 36'h0_4000_0000, 48'h0000_4000_0000);
      vecs[10] = mkv(1, 4'b0001, c_hold, c_garb, 4'b0001, 36'h0_4000_0000, 48'h0000_8000_0000);
      vecs[11] = mkv(1, 4'b0001, c_hold, c_garb, 4'b0001, 36'h0,         48'h0000_C000_0000);
      vecs[12] = mkv(1, 4'b0001, c_pre,  c_garb, 4'b0001, 36'h0,         48'h0000_C000_0000);
      vecs[13] = mkv(1, 4'b0001, c_post, c_garb, 4'b0001, 36'h0_3000_0000, 48'h0000_C000_0000);
      vecs[14] = mkv(1, 4'b0001, c_hold, c_garb, 4'b0001, 36'h0_3000_0000, 48'h0000_3000_0000);
      vecs[15] = mkv(1, 4'b0001, c_hold, c_garb, 4'b0001, 36'h0,         48'h0);
      vecs[16] = mkv(1, 4'b0001, c_acc,  c_garb, 4'b0001, 36'h0,         48'h0);
      vecs[17] = mkv(1, 4'b0001, c_hold, c_garb, 4'b0001, 36'h0_4000_0000, 48'h0);
      vecs[18] = mkv(1, 4'b0010, c_hold, c_hold, 4'b0000, 36'h0,         48'h0000_4000_0000);
      vecs[19] = mkv(1, 4'b0010, c_garb, c_hold, 4'b0000, 36'h0,         48'h0);
      vecs[20] = mkv(1, 4'b0010, c_garb, c_hold, 4'b0010, 36'h0,         48'h0);
      vecs[21] = mkv(1, 4'b0010, c_garb, c_hold, 4'b0010, 36'h0,         48'h0);
      vecs[22] = mkv(1, 4'b0010, c_garb, c_hold, 4'b0010, 36'h0,         48'h0);
      vecs[23] = mkv(1, 4'b0000, c_garb, c_hold, 4'b0000, 36'h0,         48'h0);

      reset = 1'b0;
      req = '0;
      dsp_ins_all = '0;

      for (int k = 0; k < 24; k++) begin
         reset = vecs[k].rst;
         req = vecs[k].req;
         dsp_ins_all = {c_garb, c_garb, vecs[k].c1, vecs[k].c0};
         tick();
         check($sformatf("vec%0d gnt", k),  64'(gnt),                  64'(vecs[k].gnt));
         check($sformatf("vec%0d busy", k), 64'(busy),                 64'(vecs[k].gnt != 4'b0000));
         check($sformatf("vec%0d m", k),    64'(dsp_outs_flat[83:48]), 64'(vecs[k].m));
         check($sformatf("vec%0d p", k),    64'(dsp_outs_flat[47:0]),  64'(vecs[k].p));
      end

      // Round-robin handover with client 0 re-requesting while client 2 owns.
      reset = 1'b0; req = '0; dsp_ins_all = '0;
      tick();
      reset = 1'b1;
      req = 4'b0101;
      tick();
      check("rr first grant", 64'(gnt), 64'(4'b0001));
      req = 4'b0100;
      tick();
      check("rr release gap gnt", 64'(gnt), 64'(4'b0000));
      check("rr release gap busy", 64'(busy), 64'(1'b0));
      req = 4'b0101;
      wait_grant(8, g);
      check("rr second grant", 64'(g), 64'(4'b0100));
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rr client2 held", 64'(gnt), 64'(4'b0100));
      end
      req = 4'b0001;
      wait_grant(8, g);
      check("rr third grant", 64'(g), 64'(4'b0001));

      // A request that vanishes in the cycle it would be granted gets nothing.
      req = 4'b0010;
      tick();
      tick();
      req = 4'b0000;
      tick();
      check("pulse no grant", 64'(gnt), 64'(4'b0000));
      tick();
      check("pulse still idle gnt", 64'(gnt), 64'(4'b0000));
      check("pulse still idle busy", 64'(busy), 64'(1'b0));

      // Randomized run against the reference model, including mid-calculation resets.
      reset = 1'b0;
      req = '0;
      dsp_ins_all = '0;
      model_edge();
      tick();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         reset = ($urandom_range(199) != 0);
         for (int i = 0; i < N; i++) begin
            if (req[i]) begin
               if ($urandom_range(11) == 0) req[i] = 1'b0;
            end else if ($urandom_range(5) == 0) begin
               req[i] = 1'b1;
            end
            dsp_ins_all[W*i +: W] = rand_cmd();
         end
         model_edge();
         tick();
         gexp = (mdl_owner >= 0) ? 4'(1 << mdl_owner) : 4'b0000;
         check($sformatf("rand%0d gnt", cyc),  64'(gnt),                  64'(gexp));
         check($sformatf("rand%0d busy", cyc), 64'(busy),                 64'(gexp != 4'b0000));
         check($sformatf("rand%0d m", cyc),    64'(dsp_outs_flat[83:48]), 64'(mdl_m));
         check($sformatf("rand%0d p", cyc),    64'(dsp_outs_flat[47:0]),  64'(mdl_p));
         if (n_fail > 20) break;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
